// File: rtl/spi_slave_if.sv
// SPI slave front end: assembles 10-bit command frames for a RAM and
// shifts the RAM's 8-bit read data back out on MISO.
module spi_slave_if (
  input  logic       clk,
  input  logic       rst,
  input  logic       MOSI,
  input  logic       SS_n,
  output logic       MISO,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid
);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  // Progress inside a data state: receiving, waiting on RAM, sending, finished
  typedef enum logic [1:0] {
    PH_RX,
    PH_WAIT,
    PH_TX,
    PH_DONE
  } phase_t;

  state_t     state;
  phase_t     phase;
  logic [3:0] cnt;
  logic [8:0] shreg;
  logic [6:0] tx_sr;
  logic       rd_addr_seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= PH_RX;
      cnt          <= 4'd0;
      shreg        <= 9'd0;
      tx_sr        <= 7'd0;
      rd_addr_seen <= 1'b0;
      MISO         <= 1'b0;
      rx_valid     <= 1'b0;
      rx_data      <= 10'd0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n) begin
        state <= IDLE;
        phase <= PH_RX;
        cnt   <= 4'd0;
        MISO  <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= CHK_CMD;
          CHK_CMD: begin
            shreg <= {8'd0, MOSI};
            cnt   <= 4'd0;
            phase <= PH_RX;
            if (!MOSI)
              state <= WRITE;
            else if (rd_addr_seen)
              state <= READ_DATA;
            else
              state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            unique case (phase)
              PH_RX: begin
                shreg <= {shreg[7:0], MOSI};
                if (cnt == 4'd8) begin
                  cnt      <= 4'd0;
                  rx_data  <= {shreg, MOSI};
                  rx_valid <= 1'b1;
                  if (state == READ_ADD)
                    rd_addr_seen <= 1'b1;
                  phase <= (state == READ_DATA) ? PH_WAIT : PH_DONE;
                end else begin
                  cnt <= cnt + 4'd1;
                end
              end
              PH_WAIT: begin
                if (tx_valid) begin
                  MISO  <= tx_data[7];
                  tx_sr <= tx_data[6:0];
                  cnt   <= 4'd0;
                  phase <= PH_TX;
                end
              end
              PH_TX: begin
                if (cnt == 4'd7) begin
                  MISO         <= 1'b0;
                  rd_addr_seen <= 1'b0;
                  phase        <= PH_DONE;
                end else begin
                  MISO  <= tx_sr[6];
                  tx_sr <= {tx_sr[5:0], 1'b0};
                  cnt   <= cnt + 4'd1;
                end
              end
              PH_DONE: ;
            endcase
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/spi_slave_if.md
SPI_SLAVE_IF -- requirements
Module: spi_slave_if

Interface
REQ-001 The block SHALL have no parameters; frame length is fixed at 10 command bits and 8 read-data bits.
REQ-002 clk  input  1  single clock; also the SPI serial clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 MOSI  input  1  serial data from master, sampled on rising clk, MSB first.
REQ-005 SS_n  input  1  active-low slave select; high ends or aborts any frame.
REQ-006 MISO  output  1  serial read data to master, registered, MSB first.
REQ-007 rx_data  output  10  assembled frame {cmd[1:0], payload[7:0]} to the downstream RAM din port.
REQ-008 rx_valid  output  1  one-cycle strobe qualifying rx_data.
REQ-009 tx_data  input  8  read data returned by the RAM.
REQ-010 tx_valid  input  1  qualifies tx_data; sampled only in READ_DATA after the frame is forwarded.

Function
REQ-011 The FSM SHALL have states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, encoded in a registered state variable.
REQ-012 IDLE -> CHK_CMD when SS_n=0; otherwise stay.
REQ-013 In CHK_CMD, the MOSI bit SHALL be captured as frame bit 9; next state WRITE if MOSI=0, READ_ADD if MOSI=1 and rd_addr_seen=0, READ_DATA if MOSI=1 and rd_addr_seen=1.
REQ-014 In WRITE/READ_ADD/READ_DATA, the block SHALL shift in 9 further MOSI bits (bits 8..0) on consecutive cycles using a 4-bit bit counter.
REQ-015 On the cycle after bit 0 is captured, rx_data SHALL hold the full frame and rx_valid SHALL be 1 for exactly one cycle; latency from first MOSI bit to rx_valid = 10 cycles.
REQ-016 rx_data SHALL hold its last value until the next completed frame; it SHALL NOT change on aborted frames.
REQ-017 Completion of a READ_ADD frame SHALL set rd_addr_seen=1; completion of a READ_DATA frame's MISO shift SHALL clear it; WRITE frames leave it unchanged.
REQ-018 After rx_valid, WRITE and READ_ADD SHALL remain in place with MOSI ignored until SS_n=1.
REQ-019 After rx_valid in READ_DATA, the block SHALL wait indefinitely for tx_valid=1 and capture tx_data on that edge.
REQ-020 Starting the cycle after capture, MISO SHALL present tx_data[7] down to tx_data[0], one bit per cycle (8 cycles); MISO SHALL be 0 at all other times.
REQ-021 tx_valid outside the READ_DATA wait window SHALL be ignored.
REQ-022 SS_n=1 in any non-IDLE state SHALL force IDLE on the next edge, clear the bit counter, stop MISO (0), suppress rx_valid for an incomplete frame, and leave rd_addr_seen unchanged unless the MISO shift had completed.
REQ-023 SS_n=1 coinciding with the 10th bit or with tx_valid SHALL abort: SS_n has priority over all other events.
REQ-024 Back-to-back frames SHALL require SS_n=1 for at least one cycle (return to IDLE) between frames.

Reset
REQ-025 rst=1 SHALL immediately (asynchronously) force state=IDLE, counter=0, rd_addr_seen=0, MISO=0, rx_valid=0, rx_data=10'b0.
REQ-026 Reset asserted mid-frame SHALL discard the frame with no rx_valid pulse after release.
REQ-027 After rst deasserts, the first frame SHALL start only on a subsequent SS_n=0.

Verification
REQ-028 Write addr: SS_n=0, MOSI 00_00000101 -> rx_valid one cycle with rx_data=10'b00_00000101, MISO stays 0.
REQ-029 Write data: next frame 01_10100101 -> rx_data=10'b01_10100101, rd_addr_seen unchanged (0).
REQ-030 Read addr then read data: frame 10_00000101 -> rx_data=10'b10_00000101, rd_addr_seen=1; frame 11_00000000, tx_valid=1 with tx_data=8'hA5 -> MISO sequence 1,0,1,0,0,1,0,1 then 0, rd_addr_seen=0.
REQ-031 Abort: SS_n raised after 6 bits -> no rx_valid, rx_data unchanged, state IDLE next cycle.
REQ-032 Reset mid-READ_DATA shift (after 3 MISO bits) -> MISO=0 immediately, rd_addr_seen=0, next 11_xxxxxxxx frame enters READ_ADD.
REQ-033 Stray tx_valid=1 during WRITE -> no MISO activity, no state change.
